// File: rtl/mesh_adapter_job_pe_match.sv
// Job-PE endpoint of the match-request mesh: issues request flits, reorders match-length responses.
// Optional macro MESH_ADAPTER_JOB_PE_RESP_BYPASS_EN: same-cycle bypass of a head-slot response.
module mesh_adapter_job_pe_match #(
    parameter int ADDR_WIDTH       = 16,
    parameter int MESH_W           = 64,
    parameter int MESH_X_SIZE_LOG2 = 2,
    parameter int MESH_Y_SIZE_LOG2 = 2,
    parameter int LAZY_LEN         = 4,
    parameter int LAZY_LEN_LOG2    = 2,
    parameter int MATCH_LEN_WIDTH  = 8,
    parameter int NUM_JOB_PE_LOG2  = MESH_X_SIZE_LOG2 + MESH_Y_SIZE_LOG2 - 1,
    parameter logic [MESH_X_SIZE_LOG2-1:0] SELF_X      = '0,
    parameter logic [MESH_Y_SIZE_LOG2-2:0] SELF_Y_HALF = '0,
    parameter int PE_SEL_LSB       = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        job_req_valid,
    output logic                        job_req_ready,
    input  logic [ADDR_WIDTH-1:0]       job_req_head_addr,
    input  logic [ADDR_WIDTH-1:0]       job_req_history_addr,
    output logic                        job_resp_valid,
    input  logic                        job_resp_ready,
    output logic [MATCH_LEN_WIDTH-1:0]  job_resp_match_len,
    output logic                        to_mesh_valid,
    input  logic                        to_mesh_ready,
    output logic [MESH_X_SIZE_LOG2-1:0] to_mesh_x_dst,
    output logic [MESH_Y_SIZE_LOG2-1:0] to_mesh_y_dst,
    output logic [MESH_W-1:0]           to_mesh_payload,
    input  logic                        from_mesh_valid,
    output logic                        from_mesh_ready,
    input  logic [MESH_W-1:0]           from_mesh_payload,
    output logic                        idle,
    output logic                        err_spurious
);
    localparam int RSP_W = LAZY_LEN_LOG2 + MATCH_LEN_WIDTH;
    localparam logic [LAZY_LEN_LOG2:0] FULL = (LAZY_LEN_LOG2 + 1)'(LAZY_LEN);

    logic [LAZY_LEN_LOG2-1:0]    wr_ptr_reg;
    logic [LAZY_LEN_LOG2-1:0]    rd_ptr_reg;
    logic [LAZY_LEN_LOG2:0]      count_reg;
    logic                        occ_reg  [LAZY_LEN];
    logic                        done_reg [LAZY_LEN];
    logic [MATCH_LEN_WIDTH-1:0]  len_reg  [LAZY_LEN];
    logic                        out_vld_reg;
    logic [MESH_X_SIZE_LOG2-1:0] x_reg;
    logic [MESH_Y_SIZE_LOG2-1:0] y_reg;
    logic [MESH_W-1:0]           payload_reg;
    logic                        err_reg;

    logic                        issue;
    logic                        rel_fire;
    logic                        resp_ok;
    logic                        resp_store;
    logic [LAZY_LEN_LOG2-1:0]    resp_tag;
    logic [MATCH_LEN_WIDTH-1:0]  resp_len;
    logic                        unused_payload_bits;

    assign resp_tag            = from_mesh_payload[LAZY_LEN_LOG2-1:0];
    assign resp_len            = from_mesh_payload[LAZY_LEN_LOG2 +: MATCH_LEN_WIDTH];
    assign unused_payload_bits = ^from_mesh_payload[MESH_W-1:RSP_W];

    // A response is legal only for a slot that is outstanding and not yet answered.
    assign resp_ok         = from_mesh_valid && occ_reg[resp_tag] && !done_reg[resp_tag];
    assign from_mesh_ready = 1'b1;

    assign job_req_ready = (count_reg != FULL) && (!out_vld_reg || to_mesh_ready);
    assign issue         = job_req_valid && job_req_ready;

`ifdef MESH_ADAPTER_JOB_PE_RESP_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit         = resp_ok && (resp_tag == rd_ptr_reg);
    assign job_resp_valid     = (occ_reg[rd_ptr_reg] && done_reg[rd_ptr_reg]) || bypass_hit;
    assign job_resp_match_len = bypass_hit ? resp_len : len_reg[rd_ptr_reg];
    assign resp_store         = resp_ok && !(bypass_hit && job_resp_ready);
`else
    assign job_resp_valid     = occ_reg[rd_ptr_reg] && done_reg[rd_ptr_reg];
    assign job_resp_match_len = len_reg[rd_ptr_reg];
    assign resp_store         = resp_ok;
`endif

    assign rel_fire = job_resp_valid && job_resp_ready;

    assign to_mesh_valid   = out_vld_reg;
    assign to_mesh_x_dst   = x_reg;
    assign to_mesh_y_dst   = y_reg;
    assign to_mesh_payload = payload_reg;
    assign idle            = (count_reg == '0) && !out_vld_reg;
    assign err_spurious    = err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (issue)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rel_fire)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({issue, rel_fire})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (from_mesh_valid && !resp_ok)
                err_reg <= 1'b1;
        end
    end

    // Flit register: data only changes on issue, which is blocked while a flit is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_reg <= 1'b0;
            x_reg       <= '0;
            y_reg       <= '0;
            payload_reg <= '0;
        end else begin
            if (issue) begin
                out_vld_reg <= 1'b1;
                x_reg       <= job_req_history_addr[PE_SEL_LSB +: MESH_X_SIZE_LOG2];
                y_reg       <= {SELF_Y_HALF, 1'b1};
                payload_reg <= MESH_W'({job_req_head_addr, job_req_history_addr,
                                        wr_ptr_reg, SELF_Y_HALF, SELF_X});
            end else if (to_mesh_ready) begin
                out_vld_reg <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < LAZY_LEN; gi++) begin : g_entry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                occ_reg[gi]  <= 1'b0;
                done_reg[gi] <= 1'b0;
                len_reg[gi]  <= '0;
            end else begin
                if (issue && wr_ptr_reg == LAZY_LEN_LOG2'(gi)) begin
                    occ_reg[gi]  <= 1'b1;
                    done_reg[gi] <= 1'b0;
                end else if (rel_fire && rd_ptr_reg == LAZY_LEN_LOG2'(gi)) begin
                    occ_reg[gi]  <= 1'b0;
                    done_reg[gi] <= 1'b0;
                end else if (resp_store && resp_tag == LAZY_LEN_LOG2'(gi)) begin
                    done_reg[gi] <= 1'b1;
                end
                if (resp_store && resp_tag == LAZY_LEN_LOG2'(gi))
                    len_reg[gi] <= resp_len;
            end
        end
    end
endmodule

// File: tb/tb_mesh_adapter_job_pe_match.sv
// Scoreboard bench for mesh_adapter_job_pe_match: expected flits and release order are queued at issue.
`timescale 1ns/1ps
module tb_mesh_adapter_job_pe_match;
    localparam logic [1:0] SX  = 2'd2;
    localparam logic [0:0] SYH = 1'b1;
`ifdef MESH_ADAPTER_JOB_PE_RESP_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        job_req_valid, job_req_ready;
    logic [15:0] job_req_head_addr, job_req_history_addr;
    logic        job_resp_valid, job_resp_ready;
    logic [7:0]  job_resp_match_len;
    logic        to_mesh_valid, to_mesh_ready;
    logic [1:0]  to_mesh_x_dst, to_mesh_y_dst;
    logic [63:0] to_mesh_payload;
    logic        from_mesh_valid, from_mesh_ready;
    logic [63:0] from_mesh_payload;
    logic        idle, err_spurious;

    mesh_adapter_job_pe_match #(
        .ADDR_WIDTH(16), .MESH_W(64), .MESH_X_SIZE_LOG2(2), .MESH_Y_SIZE_LOG2(2),
        .LAZY_LEN(4), .LAZY_LEN_LOG2(2), .MATCH_LEN_WIDTH(8),
        .SELF_X(SX), .SELF_Y_HALF(SYH), .PE_SEL_LSB(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .job_req_valid(job_req_valid), .job_req_ready(job_req_ready),
        .job_req_head_addr(job_req_head_addr), .job_req_history_addr(job_req_history_addr),
        .job_resp_valid(job_resp_valid), .job_resp_ready(job_resp_ready),
        .job_resp_match_len(job_resp_match_len),
        .to_mesh_valid(to_mesh_valid), .to_mesh_ready(to_mesh_ready),
        .to_mesh_x_dst(to_mesh_x_dst), .to_mesh_y_dst(to_mesh_y_dst),
        .to_mesh_payload(to_mesh_payload),
        .from_mesh_valid(from_mesh_valid), .from_mesh_ready(from_mesh_ready),
        .from_mesh_payload(from_mesh_payload),
        .idle(idle), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [71:0] flit_q[$];
    int          slot_q[$];
    logic [7:0]  rel_q[$];
    logic [7:0]  model_len [4];
    int          model_wr = 0;
    logic [71:0] mon_f;
    int          mon_s;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] exp_flit(input logic [15:0] head, input logic [15:0] hist,
                                             input int slot);
        logic [1:0]  s;
        logic [63:0] p;
        s = 2'(slot);
        p = {27'b0, head, hist, s, SYH, SX};
        return {4'b0, hist[5:4], SYH, 1'b1, p};
    endfunction

    // Monitor on the falling edge: handshakes seen here complete at the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (to_mesh_valid && to_mesh_ready) begin
                if (flit_q.size() == 0) begin
                    chk("flit_unexpected", 72'(to_mesh_valid), 72'(0));
                end else begin
                    mon_f = flit_q.pop_front();
                    chk("flit", {4'b0, to_mesh_x_dst, to_mesh_y_dst, to_mesh_payload}, mon_f);
                    $display("flit x=%0d y=%0d payload=%h", to_mesh_x_dst, to_mesh_y_dst, to_mesh_payload);
                end
            end
            if (job_resp_valid && job_resp_ready) begin
                if (slot_q.size() == 0) begin
                    chk("resp_unexpected", 72'(job_resp_valid), 72'(0));
                end else begin
                    mon_s = slot_q.pop_front();
                    chk("resp_len", 72'(job_resp_match_len), 72'(model_len[mon_s]));
                    rel_q.push_back(job_resp_match_len);
                    $display("release slot=%0d len=%0d", mon_s, job_resp_match_len);
                end
            end
            if (job_req_valid && job_req_ready) begin
                flit_q.push_back(exp_flit(job_req_head_addr, job_req_history_addr, model_wr));
                slot_q.push_back(model_wr);
                $display("issue slot=%0d head=%h hist=%h", model_wr, job_req_head_addr, job_req_history_addr);
                model_wr = (model_wr + 1) % 4;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] head, input logic [15:0] hist, output int waits);
        waits = 0;
        job_req_head_addr    = head;
        job_req_history_addr = hist;
        job_req_valid        = 1'b1;
        @(negedge clk);
        while (!job_req_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!job_req_ready)
            chk("req_timeout", 72'(job_req_ready), 72'(1));
        tick();
        job_req_valid = 1'b0;
    endtask

    task automatic set_resp(input int slot, input logic [7:0] len);
        logic [63:0] p;
        logic [1:0]  s;
        s = 2'(slot);
        p = {$urandom(), $urandom()};
        p[9:0] = {len, s};
        model_len[slot]   = len;
        from_mesh_payload = p;
        from_mesh_valid   = 1'b1;
    endtask

    task automatic send_resp(input int slot, input logic [7:0] len);
        set_resp(slot, len);
        tick();
        from_mesh_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!idle && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("idle", 72'(idle), 72'(1));
        tick();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        flit_q.delete();
        slot_q.delete();
        model_wr = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_to_mesh_valid"}, 72'(to_mesh_valid), 72'(0));
        chk({tag, "_req_ready"}, 72'(job_req_ready), 72'(1));
        chk({tag, "_resp_valid"}, 72'(job_resp_valid), 72'(0));
        chk({tag, "_resp_len"}, 72'(job_resp_match_len), 72'(0));
        chk({tag, "_idle"}, 72'(idle), 72'(1));
        chk({tag, "_err"}, 72'(err_spurious), 72'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         w;
        int         sl[$];
        logic [7:0] exp_rel[5];

        rst_n = 1'b0;
        job_req_valid = 1'b0; job_req_head_addr = '0; job_req_history_addr = '0;
        job_resp_ready = 1'b1; to_mesh_ready = 1'b1;
        from_mesh_valid = 1'b0; from_mesh_payload = '0;
        repeat (2) tick();
        chk_reset_vals("rst");
        rst_n = 1'b1;
        tick();

        // Single request, destination and tag, response latency.
        issue(16'h1234, 16'h0030, w);
        @(negedge clk);
        chk("x_dst", 72'(to_mesh_x_dst), 72'(3));
        chk("y_dst", 72'(to_mesh_y_dst), 72'(3));
        chk("tag", 72'(to_mesh_payload[4:0]), 72'(6));
        tick();
        set_resp(0, 8'd7);
        @(negedge clk);
        chk("lat_same_cycle", 72'(job_resp_valid), 72'(BYP));
        tick();
        from_mesh_valid = 1'b0;
        @(negedge clk);
        chk("lat_next_cycle", 72'(job_resp_valid), 72'(!BYP));
        tick();
        wait_idle();

        // Out-of-order responses, full ROB, wrap to slot 0.
        reset_dut();
        rel_q.delete();
        job_resp_ready = 1'b0;
        issue(16'h0100, 16'h0000, w);
        issue(16'h0101, 16'h0010, w);
        issue(16'h0102, 16'h0020, w);
        issue(16'h0103, 16'h0030, w);
        @(negedge clk);
        chk("full_ready", 72'(job_req_ready), 72'(0));
        tick();
        send_resp(3, 8'd10);
        send_resp(1, 8'd11);
        send_resp(2, 8'd12);
        send_resp(0, 8'd13);
        job_resp_ready = 1'b1;
        @(negedge clk);
        chk("release_cycle_ready", 72'(job_req_ready), 72'(0));
        tick();
        job_resp_ready = 1'b0;
        @(negedge clk);
        chk("reopen_ready", 72'(job_req_ready), 72'(1));
        tick();
        issue(16'hAAAA, 16'h0010, w);
        job_resp_ready = 1'b1;
        send_resp(0, 8'd20);
        wait_idle();
        exp_rel = '{8'd13, 8'd11, 8'd12, 8'd10, 8'd20};
        chk("rel_count", 72'(rel_q.size()), 72'(5));
        for (int i = 0; i < 5 && i < rel_q.size(); i++)
            chk($sformatf("rel_order%0d", i), 72'(rel_q[i]), 72'(exp_rel[i]));

        // Mesh backpressure: flit held stable, issue blocked, then back-to-back drain.
        to_mesh_ready = 1'b0;
        issue(16'h0201, 16'h0010, w);
        job_req_head_addr = 16'h0202; job_req_history_addr = 16'h0020; job_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 72'(to_mesh_valid), 72'(1));
            chk("stall_flit", {4'b0, to_mesh_x_dst, to_mesh_y_dst, to_mesh_payload},
                flit_q.size() > 0 ? flit_q[0] : 72'(0));
            chk("stall_ready", 72'(job_req_ready), 72'(0));
            tick();
        end
        to_mesh_ready = 1'b1;
        @(negedge clk);
        chk("unstall_ready", 72'(job_req_ready), 72'(1));
        tick();
        issue(16'h0203, 16'h0030, w);
        chk("burst_wait3", 72'(w), 72'(0));
        issue(16'h0204, 16'h0000, w);
        chk("burst_wait4", 72'(w), 72'(0));
        sl = slot_q;
        for (int i = 0; i < sl.size(); i++)
            send_resp(sl[i], 8'(8'h40 + i));
        wait_idle();

        // Spurious response to an empty slot.
        send_resp(2, 8'h55);
        @(negedge clk);
        chk("spur_err", 72'(err_spurious), 72'(1));
        chk("spur_idle", 72'(idle), 72'(1));
        chk("spur_resp_valid", 72'(job_resp_valid), 72'(0));
        repeat (3) tick();
        @(negedge clk);
        chk("spur_sticky", 72'(err_spurious), 72'(1));
        chk("spur_ready", 72'(job_req_ready), 72'(1));
        tick();

        // Asynchronous reset with two outstanding slots, then a late response.
        issue(16'h0301, 16'h0010, w);
        issue(16'h0302, 16'h0020, w);
        #2;
        rst_n = 1'b0;
        flit_q.delete();
        slot_q.delete();
        model_wr = 0;
        #1;
        chk_reset_vals("arst");
        tick();
        rst_n = 1'b1;
        tick();
        send_resp(1, 8'h77);
        @(negedge clk);
        chk("late_err", 72'(err_spurious), 72'(1));
        chk("late_resp_valid", 72'(job_resp_valid), 72'(0));
        chk("late_idle", 72'(idle), 72'(1));
        tick();

        chk("flit_q_empty", 72'(flit_q.size()), 72'(0));
        chk("slot_q_empty", 72'(slot_q.size()), 72'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mesh_adapter_job_pe_match.md
# mesh_adapter_job_pe_match

Job-PE-side endpoint of the match-request mesh. It accepts hash-chain match requests from one job PE and assigns each a reorder slot. It packs each request into a mesh flit aimed at a shared match PE and collects the match-length responses, which may return out of order. Match lengths go back to the job PE strictly in issue order; the shared-match-PE mesh adapter is the far end of every request this block sends.

## Interface
Parameters (widths come from `parameters.vh`: `ADDR_WIDTH`, `MESH_W`, `MESH_X_SIZE_LOG2`, `MESH_Y_SIZE_LOG2`, `LAZY_LEN`, `LAZY_LEN_LOG2`, `MATCH_LEN_WIDTH`, `NUM_JOB_PE_LOG2` = X_LOG2+Y_LOG2-1):
- SELF_X, 0, mesh X coordinate of this job PE.
- SELF_Y_HALF, 0, job-PE row index; the physical Y is {SELF_Y_HALF,1'b0}. Width MESH_Y_SIZE_LOG2-1.
- PE_SEL_LSB, 4, LSB of the history_addr field that selects the target match-PE column.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- job_req_valid / job_req_ready  in / out  1  request handshake from the job PE.
- job_req_head_addr  in  ADDR_WIDTH  current head address.
- job_req_history_addr  in  ADDR_WIDTH  candidate history address.
- job_resp_valid / job_resp_ready  out / in  1  in-order result handshake.
- job_resp_match_len  out  MATCH_LEN_WIDTH  match length for the oldest request.
- to_mesh_valid / to_mesh_ready  out / in  1  request flit handshake.
- to_mesh_x_dst  out  MESH_X_SIZE_LOG2  destination column.
- to_mesh_y_dst  out  MESH_Y_SIZE_LOG2  destination row.
- to_mesh_payload  out  MESH_W  request flit.
- from_mesh_valid / from_mesh_ready  in / out  1  response flit handshake.
- from_mesh_payload  in  MESH_W  response flit.
- idle  out  1  high when no slot is occupied and the output register is empty.
- err_spurious  out  1  sticky flag: a response arrived for a slot that is not outstanding.

## Operation
- ROB state: LAZY_LEN entries, each holding occ, done and len. Pointers: wr_ptr and rd_ptr, LAZY_LEN_LOG2 bits each, both wrap modulo LAZY_LEN. Occupancy count: LAZY_LEN_LOG2+1 bits.
- Issue: job_req_ready = (count != LAZY_LEN) && (!out_vld || to_mesh_ready).
- On issue:
  - entry[wr_ptr] ← occ=1, done=0.
  - Output register loads the payload: low bits {head_addr, history_addr, tag}, upper bits zero-padded to MESH_W.
  - tag = {wr_ptr, SELF_Y_HALF, SELF_X}.
  - x_dst = history_addr[PE_SEL_LSB +: MESH_X_SIZE_LOG2]; y_dst = {SELF_Y_HALF, 1'b1}.
  - wr_ptr++.
- Response:
  - from_mesh_ready is tied to 1; the slot is reserved at issue, so no backpressure is needed.
  - local_tag = payload[LAZY_LEN_LOG2-1:0]; len = payload[LAZY_LEN_LOG2 +: MATCH_LEN_WIDTH]. Upper payload bits are ignored.
  - If entry[local_tag].occ && !done: set done=1 and store len.
  - Otherwise: drop the flit, set err_spurious, leave the ROB unchanged.
- Release: job_resp_valid = occ[rd_ptr] && done[rd_ptr]. On handshake: clear occ and done, rd_ptr++.
- count increments on issue only, decrements on release only, and is unchanged when both happen in the same cycle.

## Timing
- Reset values: to_mesh_valid=0, job_req_ready=1, job_resp_valid=0, job_resp_match_len=0, idle=1, err_spurious=0. All pointers, counts, occ and done bits are 0. len storage also resets to 0.
- Request path: the flit is registered, so to_mesh_valid rises the cycle after the job handshake. Throughput is one flit per cycle while to_mesh_ready=1.
- to_mesh_* holds stable while to_mesh_valid && !to_mesh_ready.
- Response path:
  - Default: a response for the head slot gives job_resp_valid the next cycle.
  - A response for a non-head slot stays held until every older slot has been released.
- Full: at count==LAZY_LEN, job_req_ready=0. A release in the same cycle does not reopen issue until the next cycle.
- Simultaneous issue and response on different slots: both take effect. Reuse of a slot is impossible while occ=1.
- Asynchronous reset mid-operation discards all outstanding slots. Late responses arriving after reset set err_spurious.

## Configuration
- `MESH_ADAPTER_JOB_PE_RESP_BYPASS_EN` defined:
  - A valid response whose local_tag==rd_ptr and whose entry is occ && !done drives job_resp_valid and job_resp_match_len combinationally in the same cycle.
  - If job_resp_ready=1, the slot releases immediately and done is never stored.
  - If job_resp_ready=0, the response is stored as normal.
- Undefined: responses always pass through the ROB, with one-cycle minimum latency.

## Test plan
- Reset, then a single request with history_addr=0x0030, PE_SEL_LSB=4, X_LOG2=2, SELF_Y_HALF=1 → x_dst=3, y_dst=2'b11, tag slot 0. A response with len=7, tag 0 then gives job_resp len=7 one cycle later (zero cycles with bypass).
- Issue 4 requests (LAZY_LEN=4) and return responses in order 3,1,2,0 with lens 10,11,12,13 → releases come out as 13,11,12,10 in slot order 0..3.
- Fill all 4 slots with responses withheld → job_req_ready=0. One release re-raises ready the next cycle, and the new request takes slot 0 after wrap.
- Hold to_mesh_ready=0 for 5 cycles → to_mesh_payload stays stable and job_req_ready=0. Ready=1 drains with one flit per cycle.
- Response carrying the tag of an unoccupied slot → dropped, err_spurious=1 and sticky, ROB count unchanged.
- Assert rst_n low with 2 slots outstanding → all outputs return to reset values asynchronously; a later response for slot 1 sets err_spurious.
